// File: rtl/seq_mult_pkg.sv
// ============================================================================
// Module      : seq_mult_pkg
// Description : Shared ALU definitions for the sequential multiplier: FSM
//               state encoding and the operand-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int width(input int s);
        return 2 ** s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mult_if.sv
// ============================================================================
// Module      : seq_mult_if
// Description : Operand/product handshake bundle for seq_mult. Carries the
//               signed_op qualifier when SEQ_MULT_SIGNED_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_mult_if
    import seq_mult_pkg::*;
#(
    parameter int S = 3
);
    localparam int c_W = width(S);

    logic               in_valid;
    logic               in_ready;
    logic [c_W-1:0]     a;
    logic [c_W-1:0]     b;
`ifdef SEQ_MULT_SIGNED_EN
    logic               signed_op;
`endif
    logic               out_valid;
    logic               out_ready;
    logic [2*c_W-1:0]   product;
    logic               busy;

`ifdef SEQ_MULT_SIGNED_EN
    modport master (
        output in_valid, a, b, signed_op, out_ready,
        input  in_ready, out_valid, product, busy
    );
    modport slave (
        input  in_valid, a, b, signed_op, out_ready,
        output in_ready, out_valid, product, busy
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
`endif

endinterface

`default_nettype wire

// File: rtl/multi_add.sv
// ============================================================================
// Module      : multi_add
// Description : W+1-bit add/subtract step. Operands are zero- or
//               sign-extended by sgn; sub inverts b, cin completes negation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_add
    import seq_mult_pkg::*;
#(
    parameter int S = 3
) (
    input  logic [width(S)-1:0] a,
    input  logic [width(S)-1:0] b,
    input  logic                sgn,
    input  logic                sub,
    input  logic                cin,
    output logic [width(S):0]   sum
);
    localparam int c_W = width(S);

    logic [c_W:0] w_ax;
    logic [c_W:0] w_bx;

    assign w_ax = {sgn & a[c_W-1], a};
    assign w_bx = {sgn & b[c_W-1], b} ^ {(c_W + 1){sub}};
    assign sum  = w_ax + w_bx + {{c_W{1'b0}}, cin};

endmodule

`default_nettype wire

// File: rtl/seq_mult.sv
// ============================================================================
// Module      : seq_mult
// Description : Shift-and-add multiplier, one partial product per clock.
//               SEQ_MULT_SIGNED_EN adds two's-complement operation (signed_op).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int S = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_mult_if.slave     bus
);
    localparam int            c_W        = width(S);
    localparam logic [S-1:0]  c_CNT_LAST = S'(c_W - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_W-1:0]     r_mcand;
    logic [2*c_W-1:0]   r_acc;
    logic [S-1:0]       r_cnt;

    logic               w_last;
    logic               w_take;
    logic               w_sgn;
    logic               w_sub;
    logic [c_W-1:0]     w_addend;
    logic [c_W:0]       w_sum;

`ifdef SEQ_MULT_SIGNED_EN
    logic               r_signed;
    assign w_sgn = r_signed;
`else
    assign w_sgn = 1'b0;
`endif

    assign w_last   = (r_cnt == c_CNT_LAST);
    assign w_take   = r_acc[0];
    assign w_addend = w_take ? r_mcand : '0;
    // Negative multiplier weight lives only in its MSB, handled on the last step.
    assign w_sub    = w_sgn & w_last & w_take;

    multi_add #(
        .S   (S)
    ) u_add (
        .a   (r_acc[2*c_W-1:c_W]),
        .b   (w_addend),
        .sgn (w_sgn),
        .sub (w_sub),
        .cin (w_sub),
        .sum (w_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (bus.in_valid)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)        w_state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) w_state_nxt = ST_IDLE;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            r_signed <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_mcand  <= bus.a;
                        r_acc    <= {{c_W{1'b0}}, bus.b};
                        r_cnt    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
                        r_signed <= bus.signed_op;
`endif
                    end
                end
                ST_RUN: begin
                    // Top bit of the sum is carry (unsigned) or sign (signed).
                    r_acc <= {w_sum, r_acc[c_W-1:1]};
                    r_cnt <= r_cnt + S'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.busy      = (r_state == ST_RUN);
    assign bus.out_valid = (r_state == ST_DONE);
    assign bus.product   = (r_state == ST_DONE) ? r_acc : '0;

endmodule

`default_nettype wire

// File: tb/tb_seq_mult.sv
// ============================================================================
// Module      : tb_seq_mult
// Description : Scoreboard bench for seq_mult (S=3): directed vectors,
//               back-pressure, resets mid-operation and random pairs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_mult;
    logic clk;
    logic rst_n;

    seq_mult_if #(.S(3)) bus ();

    seq_mult #(.S(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [15:0] sb_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Product must equal the queue head for every cycle it is presented.
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected out_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    check("product", 32'(bus.product), 32'(sb_q[0]));
                    if (bus.out_ready) void'(sb_q.pop_front());
                end
            end
        end
    endtask

    task automatic set_sgn(input bit sgn);
`ifdef SEQ_MULT_SIGNED_EN
        bus.signed_op = sgn;
`else
        if (sgn) $display("signed vector requested in unsigned build");
`endif
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit sgn,
                          input logic [15:0] exp, input int stall);
        int t;
        int lat;
        bit bad;
        @(posedge clk);
        #1;
        bus.a         = a;
        bus.b         = b;
        set_sgn(sgn);
        bus.in_valid  = 1'b1;
        bus.out_ready = (stall == 0);
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            check("accept timeout", 32'(bus.in_ready), 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        sb_q.push_back(exp);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 1;
        bad = 1'b0;
        while (lat < 40) begin
            @(negedge clk);
            if (bus.out_valid) break;
            if (bus.in_ready || !bus.busy) bad = 1'b1;
            @(posedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'd9);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = (i % 2 == 0);
            bus.a        = 8'hEE;
            bus.b        = 8'h11;
            if (bus.in_ready || bus.busy) bad = 1'b1;
        end
        if (stall > 0) begin
            @(posedge clk);
            #1;
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        check("in_ready low while busy/done", 32'(bad), 32'd0);
        t = 0;
        while (t < 50) begin
            @(negedge clk);
            if (!bus.out_valid) break;
            t++;
        end
        check("in_ready after handshake", 32'({bus.in_ready, bus.out_valid}), 32'b10);
    endtask

    initial begin
        logic [7:0]         ra;
        logic [7:0]         rb;
        logic signed [15:0] sa;
        logic signed [15:0] sbv;
        bit                 rs;
        int                 t;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        set_sgn(1'b0);
        fork
            monitor_loop();
        join_none

        repeat (2) @(negedge clk);
        check("reset state", 32'({bus.in_ready, bus.out_valid, bus.busy, bus.product}),
              32'({1'b1, 1'b0, 1'b0, 16'h0000}));
        @(posedge clk);
        #1 rst_n = 1'b1;

        run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
        run_op(8'h00, 8'hA5, 1'b0, 16'h0000, 0);
        run_op(8'h01, 8'h80, 1'b0, 16'h0080, 0);
        run_op(8'h0C, 8'h0D, 1'b0, 16'h009C, 5);
        run_op(8'hAA, 8'h55, 1'b0, 16'h3872, 2);
        run_op(8'h12, 8'h34, 1'b0, 16'h03A8, 0);
        run_op(8'h10, 8'h10, 1'b0, 16'h0100, 1);
        run_op(8'h7F, 8'h02, 1'b0, 16'h00FE, 0);

        // Reset in RUN cycle 4 of 0x37 x 0x21.
        @(posedge clk);
        #1;
        bus.a = 8'h37; bus.b = 8'h21; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("busy before abort", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort in RUN", 32'({bus.in_ready, bus.out_valid, bus.busy, bus.product}),
              32'({1'b1, 1'b0, 1'b0, 16'h0000}));
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_op(8'h03, 8'h05, 1'b0, 16'h000F, 0);

        // Reset while a product is held in DONE.
        @(posedge clk);
        #1;
        bus.a = 8'h0C; bus.b = 8'h0D; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        sb_q.push_back(16'h009C);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        t = 0;
        while (!bus.out_valid && t < 40) begin
            @(posedge clk);
            #1 t++;
        end
        check("reached DONE", 32'(bus.out_valid), 32'd1);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort in DONE", 32'({bus.in_ready, bus.out_valid, bus.product}),
              32'({1'b1, 1'b0, 16'h0000}));
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        run_op(8'h03, 8'h05, 1'b0, 16'h000F, 0);

`ifdef SEQ_MULT_SIGNED_EN
        run_op(8'hFF, 8'hFF, 1'b1, 16'h0001, 0);
        run_op(8'h80, 8'h7F, 1'b1, 16'hC080, 1);
        run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 0);
        run_op(8'h80, 8'h80, 1'b1, 16'h4000, 0);
        run_op(8'h7F, 8'hFF, 1'b1, 16'hFF81, 2);
        run_op(8'h05, 8'hFD, 1'b1, 16'hFFF1, 0);
`endif

        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            sa  = rs ? {{8{ra[7]}}, ra} : {8'h00, ra};
            sbv = rs ? {{8{rb[7]}}, rb} : {8'h00, rb};
            run_op(ra, rb, rs, 16'(sa * sbv), int'($urandom_range(0, 3)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
